// File: rtl/vga_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_reader
// Description : 640x480@60 VGA timing generator that scans a 256x256 window
//               out of video memory. It presents a combinational read address
//               and registers colour and syncs with one pixel of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_reader #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned WIN_COL0  = 192,
  parameter int unsigned WIN_ROW0  = 112
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oReadAddress,
  input  logic [2:0]  iReadData,
  output logic        oVGA_RED,
  output logic        oVGA_GREEN,
  output logic        oVGA_BLUE,
  output logic        oVGA_HSYNC,
  output logic        oVGA_VSYNC,
  output logic        oVBlank,
  output logic        oFrameStart
);

  // Counter limits and decode boundaries, all in 10-bit counter space
  localparam logic [9:0] c_h_last      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] c_v_last      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] c_h_visible   = 10'(H_VISIBLE);
  localparam logic [9:0] c_v_visible   = 10'(V_VISIBLE);
  localparam logic [9:0] c_hs_start    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_hs_end      = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_vs_start    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_vs_end      = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] c_win_h_start = 10'(WIN_COL0);
  localparam logic [9:0] c_win_h_end   = 10'(WIN_COL0 + 256);
  localparam logic [9:0] c_win_v_start = 10'(WIN_ROW0);
  localparam logic [9:0] c_win_v_end   = 10'(WIN_ROW0 + 256);
  localparam logic [7:0] c_win_col0_lo = 8'(WIN_COL0);
  localparam logic [7:0] c_win_row0_lo = 8'(WIN_ROW0);

  logic       tick_q, tick_d;
  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vblank_q, vblank_d;
  logic       frame_start_q, frame_start_d;

  logic       w_in_window;
  logic       w_in_visible;
  logic       w_in_hsync;
  logic       w_in_vsync;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [7:0] w_col_off;
  logic [7:0] w_row_off;

  // Position decode of the current counter values
  always_comb begin
    w_in_window  = (h_count_q >= c_win_h_start) && (h_count_q < c_win_h_end) &&
                   (v_count_q >= c_win_v_start) && (v_count_q < c_win_v_end);
    w_in_visible = (h_count_q < c_h_visible) && (v_count_q < c_v_visible);
    w_in_hsync   = (h_count_q >= c_hs_start) && (h_count_q < c_hs_end);
    w_in_vsync   = (v_count_q >= c_vs_start) && (v_count_q < c_vs_end);
    w_h_wrap     = (h_count_q == c_h_last);
    w_v_wrap     = (v_count_q == c_v_last);
    // Subtracting the low bytes equals the 8-bit truncation of the full difference
    w_col_off    = h_count_q[7:0] - c_win_col0_lo;
    w_row_off    = v_count_q[7:0] - c_win_row0_lo;
    oReadAddress = w_in_window ? {w_row_off, w_col_off} : 16'h0000;
  end

  // Next-state: counters advance and outputs capture only on pixel-tick clocks
  always_comb begin
    tick_d        = ~tick_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    vblank_d      = vblank_q;
    frame_start_d = 1'b0;
    if (tick_q) begin
      if (w_h_wrap) begin
        h_count_d = 10'd0;
        v_count_d = w_v_wrap ? 10'd0 : v_count_q + 10'd1;
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
      // Memory data belongs to the position the address was driven from,
      // so it is captured together with the syncs of that same position
      rgb_d         = (w_in_window && w_in_visible) ? iReadData : 3'b000;
      hsync_d       = ~w_in_hsync;
      vsync_d       = ~w_in_vsync;
      vblank_d      = (v_count_q >= c_v_visible);
      frame_start_d = w_h_wrap && w_v_wrap;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tick_q        <= 1'b0;
      h_count_q     <= 10'd0;
      v_count_q     <= 10'd0;
      rgb_q         <= 3'b000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign oVGA_RED    = rgb_q[2];
  assign oVGA_GREEN  = rgb_q[1];
  assign oVGA_BLUE   = rgb_q[0];
  assign oVGA_HSYNC  = hsync_q;
  assign oVGA_VSYNC  = vsync_q;
  assign oVBlank     = vblank_q;
  assign oFrameStart = frame_start_q;

endmodule
`default_nettype wire

// File: doc/vga_scan_reader.md
VGA_SCAN_READER -- requirements
Module: vga_scan_reader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, HSYNC pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, VSYNC pulse width in lines
- V_BACK, 33, vertical back porch in lines
- WIN_COL0, 192, first window column
- WIN_ROW0, 112, first window row
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- Clock, input, 1, 50 MHz system clock
- Reset, input, 1, asynchronous active-low reset
- oReadAddress, output, 16, video memory read address {row[7:0], col[7:0]}
- iReadData, input, 3, {R,G,B} from video memory, valid one Clock after address
- oVGA_RED, output, 1, red
- oVGA_GREEN, output, 1, green
- oVGA_BLUE, output, 1, blue
- oVGA_HSYNC, output, 1, horizontal sync, active low
- oVGA_VSYNC, output, 1, vertical sync, active low
- oVBlank, output, 1, high while vCount >= V_VISIBLE
- oFrameStart, output, 1, one-Clock pulse at frame wrap
REQ-003 The block SHALL have one clock domain (Clock); reset is asynchronous and active-low (Reset).

Function
REQ-004 An internal pixel tick SHALL toggle every Clock, giving a 25 MHz pixel rate; counters advance only on Clocks where the tick is 1.
REQ-005 hCount SHALL count 0..799 (H total 800) and wrap to 0; vCount SHALL increment only on hCount wrap, count 0..524 (V total 525), and wrap to 0.
REQ-006 The raw HSYNC decode SHALL be low for hCount in 656..751; the raw VSYNC decode SHALL be low for vCount in 490..491.
REQ-007 The window SHALL be 256x256: hCount in 192..447 and vCount in 112..367.
REQ-008 oReadAddress SHALL be combinational from the counters: {(vCount-112)[7:0], (hCount-192)[7:0]} inside the window, and 16'h0000 outside it.
REQ-009 On each pixel-tick edge, the output registers SHALL capture iReadData if the previous counter position was in the window, else 3'b000; HSYNC and VSYNC SHALL be captured from the same position. RGB and syncs therefore share exactly one pixel period of latency.
REQ-010 Outside the visible area (hCount>=640 or vCount>=480), RGB SHALL be 0.
REQ-011 oFrameStart SHALL pulse high for exactly one Clock, on the Clock where the counters wrap from (799,524) to (0,0).
REQ-012 oVBlank SHALL be registered and track vCount >= 480 with the same one-pixel latency as the syncs.
REQ-013 iReadData SHALL be ignored on Clocks that are not capture edges; a memory write to the address currently being read has undefined color for that single pixel only.
REQ-014 Counter arithmetic SHALL be unsigned, 10 bits each; window subtraction SHALL be truncated to 8 bits.

Reset
REQ-015 While Reset=0, the following SHALL hold regardless of Clock: tick=0, hCount=0, vCount=0, RGB=000, HSYNC=1, VSYNC=1, oVBlank=0, oFrameStart=0.
REQ-016 On Reset release, the first pixel advance SHALL occur on the second rising Clock edge.
REQ-017 Reset asserted mid-frame SHALL clear outputs immediately, and scanning SHALL restart at (0,0).

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Free run 2 frames: HSYNC period 1600 Clocks, low 192 Clocks; VSYNC period 840000 Clocks, low 3200 Clocks; oFrameStart interval 840000 Clocks.
- Memory model returning 3'b101 everywhere: RGB=101 exactly for 256 pixels per line on 256 lines; first lit pixel is one pixel after counters reach (192,112).
- Position check: at counters (200,120), oReadAddress=16'h0808; at (191,112) and (448,112), oReadAddress=0.
- Memory model returning {addr[2:0]}: output color sequence across a window line is 0,1,2..7 repeating, aligned with HSYNC.
- Reset pulsed low at (300,200): all outputs at reset values within the same Clock; after release, the next oFrameStart arrives 840000 Clocks later.
- oVBlank rises one pixel after vCount reaches 480 and falls one pixel after vCount wraps to 0.
